// File: rtl/himax_roi_scheduler_if.sv
// Downscaler capture handshake and ML engine handshake seen by himax_roi_scheduler.
interface himax_roi_scheduler_if;
  logic [2:0] o_frame_sel;
  logic       o_rd_rdy;
  logic       i_rd_done;
  logic       o_ml_start;
  logic [2:0] o_ml_win;
  logic       i_ml_done;

  modport master (
    output o_frame_sel, o_rd_rdy, o_ml_start, o_ml_win,
    input  i_rd_done, i_ml_done
  );

  modport slave (
    input  o_frame_sel, o_rd_rdy, o_ml_start, o_ml_win,
    output i_rd_done, i_ml_done
  );
endinterface

// File: rtl/himax_roi_scheduler.sv
// Walks the enabled ROI windows: select, settle, capture, run ML, repeat.
// Optional capture timeout is built when HIMAX_ROI_TIMEOUT_EN is defined.
module himax_roi_scheduler #(
  parameter int unsigned SETTLE_FRAMES  = 1,
  parameter int unsigned TIMEOUT_FRAMES = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_enable,
  input  logic [5:0]                   i_win_mask,
  input  logic                         i_cam_vsync,
  himax_roi_scheduler_if.master        bus,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SETTLE_W = 3;
  localparam int unsigned TO_W     = 4;
  localparam logic [IDX_W-1:0] FULL_FRAME  = IDX_W'(5);
  localparam bit               SKIP_SETTLE = (SETTLE_FRAMES == 0);

  if (SETTLE_FRAMES > 7 || TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 15) begin : g_bad_param
    $error("himax_roi_scheduler: SETTLE_FRAMES or TIMEOUT_FRAMES out of range");
  end

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, ARM, ML_START, ML_WAIT
  } state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     cur, cur_d, frame_sel_d, ml_win_d;
  logic [SETTLE_W-1:0]  settle_cnt, settle_d;
  logic                 rd_rdy_d, ml_start_d, busy_d;
  logic                 vs_s1, vs_s2, vs_s3;
  logic                 fe;
  logic                 to_hit;

  // Next enabled window after cur, wrapping 5->0; cur itself is tried last.
  function automatic logic [IDX_W-1:0] next_win(input logic [IDX_W-1:0] c,
                                                input logic [5:0] mask);
    logic [IDX_W-1:0] idx;
    logic             found;
    next_win = c;
    found    = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      idx = IDX_W'((int'(c) + k) % 6);
      if (!found && mask[idx]) begin
        next_win = idx;
        found    = 1'b1;
      end
    end
  endfunction

  // vsync synchronizer; fe marks the end of an active frame
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= i_cam_vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign fe = vs_s3 & ~vs_s2;

`ifdef HIMAX_ROI_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == ARM) && i_enable && fe && !bus.i_rd_done &&
                  (({1'b0, to_cnt} + 5'd1) >= 5'(TIMEOUT_FRAMES));

  // Frame ends seen while waiting in ARM; cleared whenever ARM is not active
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state != ARM) begin
      to_cnt <= '0;
    end else if (fe && to_cnt != TO_W'(TIMEOUT_FRAMES)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_timeout <= 1'b0;
    end else if (!i_enable) begin
      o_timeout <= 1'b0;
    end else if (to_hit) begin
      o_timeout <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      cur             <= FULL_FRAME;
      settle_cnt      <= '0;
      bus.o_frame_sel <= FULL_FRAME;
      bus.o_rd_rdy    <= 1'b0;
      bus.o_ml_start  <= 1'b0;
      bus.o_ml_win    <= '0;
      o_busy          <= 1'b0;
    end else begin
      state           <= state_d;
      cur             <= cur_d;
      settle_cnt      <= settle_d;
      bus.o_frame_sel <= frame_sel_d;
      bus.o_rd_rdy    <= rd_rdy_d;
      bus.o_ml_start  <= ml_start_d;
      bus.o_ml_win    <= ml_win_d;
      o_busy          <= busy_d;
    end
  end

  // Next state; an active ML job always runs to i_ml_done
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (i_enable && (i_win_mask != '0)) state_d = SELECT;
      SELECT: begin
        if (!i_enable || (i_win_mask == '0)) state_d = IDLE;
        else if (SKIP_SETTLE)               state_d = ARM;
        else                                 state_d = SETTLE;
      end
      SETTLE: begin
        if (!i_enable) state_d = IDLE;
        else if ((settle_cnt == '0) || (fe && settle_cnt == SETTLE_W'(1))) state_d = ARM;
      end
      ARM: begin
        if (!i_enable)             state_d = IDLE;
        else if (bus.i_rd_done)    state_d = ML_START;
        else if (to_hit)           state_d = SELECT;
      end
      ML_START: state_d = ML_WAIT;
      ML_WAIT:  if (bus.i_ml_done) state_d = i_enable ? SELECT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Register inputs for outputs and datapath
  always_comb begin
    cur_d       = cur;
    frame_sel_d = bus.o_frame_sel;
    settle_d    = settle_cnt;
    ml_win_d    = bus.o_ml_win;
    rd_rdy_d    = (state_d == ARM);
    ml_start_d  = (state_d == ML_START);
    busy_d      = (state_d != IDLE);
    if (state == SELECT && state_d != IDLE) begin
      cur_d       = next_win(cur, i_win_mask);
      frame_sel_d = cur_d;
      settle_d    = SETTLE_W'(SETTLE_FRAMES);
    end
    if (state == SETTLE && fe && settle_cnt != '0) begin
      settle_d = settle_cnt - SETTLE_W'(1);
    end
    if (state == ARM && state_d == ML_START) begin
      ml_win_d = cur;
    end
  end

endmodule
